mem_arbiter: RTL and testbench

- Two-master, single-slave arbiter that shares the data memory port between two requesters, for example the CPU data port (master 0) and an IO/DMA engine (master 1).
- Uses the codebase's read/write/ready handshake on both sides.
- Round-robin grant, held for the whole transaction.
- Registered memory request and a watchdog that aborts a transaction when memory never answers.

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between two masters.
// Round-robin selection on contention, grant held for a whole transaction,
// registered memory request, and a watchdog that aborts a transaction when
// memory never answers.
//
// Handshake (both sides): a requester raises read or write (write wins if
// both are high) together with addr/wdata and holds them stable until it
// samples ready or err high at a rising edge; it drops the request at that
// same edge. ready/err are single-cycle pulses and rdata is valid only while
// ready is high. On the memory side the strobe stays high until mem_ready is
// sampled high, or until the watchdog aborts the transaction.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_ready,
   output logic                  m0_err,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_ready,
   output logic                  m1_err,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic [1:0]            grant,
   output logic [7:0]            err_count
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   // Watchdog fires on the TIMEOUT-th BUSY edge, i.e. when the counter
   // (cleared on entry to BUSY) still holds TIMEOUT-1.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t                state;
   logic                  last_m1;   // 1: master 1 was served last
   logic                  owner_m1;  // owner of the current transaction
   logic [7:0]            cnt;

   logic                  m0_req;
   logic                  m1_req;
   logic                  pick_m1;
   logic                  sel_write;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [DATA_WIDTH-1:0] resp_data;

   // Request decode and round-robin pick: on contention the master not
   // served last wins; last_m1 resets to 1 so the first contention goes to m0.
   always_comb begin
      m0_req    = m0_read | m0_write;
      m1_req    = m1_read | m1_write;
      pick_m1   = m1_req & (~m0_req | ~last_m1);
      sel_write = pick_m1 ? m1_write : m0_write;
      sel_addr  = pick_m1 ? m1_addr  : m0_addr;
      sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
      resp_data = mem_write ? '0 : mem_rdata;
   end

   // Arbitration FSM with registered memory request and master responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_m1   <= 1'b1;
         owner_m1  <= 1'b0;
         cnt       <= 8'd0;
         grant     <= 2'b00;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         m0_ready  <= 1'b0;
         m0_err    <= 1'b0;
         m0_rdata  <= '0;
         m1_ready  <= 1'b0;
         m1_err    <= 1'b0;
         m1_rdata  <= '0;
         err_count <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_req | m1_req) begin
                  owner_m1  <= pick_m1;
                  grant     <= pick_m1 ? 2'b10 : 2'b01;
                  mem_write <= sel_write;
                  mem_read  <= ~sel_write;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  cnt       <= 8'd0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  // A completion on the watchdog edge still counts as success.
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  if (owner_m1) begin
                     m1_ready <= 1'b1;
                     m1_rdata <= resp_data;
                  end else begin
                     m0_ready <= 1'b1;
                     m0_rdata <= resp_data;
                  end
                  state <= RESP;
               end else if (cnt == TO_LAST) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  if (owner_m1) begin
                     m1_err <= 1'b1;
                  end else begin
                     m0_err <= 1'b1;
                  end
                  if (err_count != 8'hFF) begin
                     err_count <= err_count + 8'd1;
                  end
                  state <= RESP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RESP: begin
               m0_ready <= 1'b0;
               m0_err   <= 1'b0;
               m0_rdata <= '0;
               m1_ready <= 1'b0;
               m1_err   <= 1'b0;
               m1_rdata <= '0;
               grant    <= 2'b00;
               last_m1  <= owner_m1;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a cycle-by-cycle vector table for single
// transactions and round-robin contention, then hand-written sequences for
// watchdog abort, asynchronous reset mid-transaction and the
// completion-on-timeout-edge case.
module tb_mem_arbiter;

   localparam logic [31:0] A0 = 32'h0000_0010;
   localparam logic [31:0] W0 = 32'hA5A5_0000;
   localparam logic [31:0] A1 = 32'h0000_0020;
   localparam logic [31:0] W1 = 32'h1234_5678;
   localparam logic [31:0] Z  = 32'h0;
   localparam logic        T  = 1'b1;
   localparam logic        F  = 1'b0;

   typedef struct {
      logic        m0_rd;
      logic        m0_wr;
      logic        m1_rd;
      logic        m1_wr;
      logic        rdy;
      logic [31:0] rdata;
      logic [1:0]  grant;
      logic        mrd;
      logic        mwr;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic        r0;
      logic [31:0] rd0;
      logic        r1;
      logic [31:0] rd1;
      logic        e0;
      logic        e1;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ready, m0_err, m1_ready, m1_err;
   logic        mem_read, mem_write, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  grant;
   logic [7:0]  err_count;

   int n_assert = 0;
   int n_fail   = 0;

   vec_t vecs[21];

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
      .m0_err(m0_err),
      .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
      .m1_err(m1_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .grant(grant), .err_count(err_count)
   );

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      m0_read   = v.m0_rd;
      m0_write  = v.m0_wr;
      m1_read   = v.m1_rd;
      m1_write  = v.m1_wr;
      mem_ready = v.rdy;
      mem_rdata = v.rdata;
   endtask

   task automatic check_out(input string tag, input vec_t v);
      chk({tag, " grant"},     32'(grant),     32'(v.grant));
      chk({tag, " mem_read"},  32'(mem_read),  32'(v.mrd));
      chk({tag, " mem_write"}, 32'(mem_write), 32'(v.mwr));
      chk({tag, " mem_addr"},  mem_addr,       v.maddr);
      chk({tag, " mem_wdata"}, mem_wdata,      v.mwdata);
      chk({tag, " m0_ready"},  32'(m0_ready),  32'(v.r0));
      chk({tag, " m0_rdata"},  m0_rdata,       v.rd0);
      chk({tag, " m1_ready"},  32'(m1_ready),  32'(v.r1));
      chk({tag, " m1_rdata"},  m1_rdata,       v.rd1);
      chk({tag, " m0_err"},    32'(m0_err),    32'(v.e0));
      chk({tag, " m1_err"},    32'(m1_err),    32'(v.e1));
   endtask

   initial begin
      vec_t zero;
      // Inputs during a cycle -> outputs expected just after the next edge.
      // m0 read 0x10, ready at first BUSY edge; mem_ready in IDLE ignored.
      vecs[0]  = '{T,F,F,F,F,Z,            2'b01,T,F,A0,W0, F,Z,F,Z,F,F};
      vecs[1]  = '{T,F,F,F,T,32'hDEADBEEF, 2'b01,F,F,A0,W0, T,32'hDEADBEEF,F,Z,F,F};
      vecs[2]  = '{T,F,F,F,F,Z,            2'b00,F,F,A0,W0, F,Z,F,Z,F,F};
      vecs[3]  = '{F,F,F,F,T,32'hCAFEF00D, 2'b00,F,F,A0,W0, F,Z,F,Z,F,F};
      // m1 write 0x20, memory ready on the third BUSY edge.
      vecs[4]  = '{F,F,F,T,F,Z,            2'b10,F,T,A1,W1, F,Z,F,Z,F,F};
      vecs[5]  = '{F,F,F,T,F,Z,            2'b10,F,T,A1,W1, F,Z,F,Z,F,F};
      vecs[6]  = '{F,F,F,T,F,Z,            2'b10,F,T,A1,W1, F,Z,F,Z,F,F};
      vecs[7]  = '{F,F,F,T,T,32'hFFFF0000, 2'b10,F,F,A1,W1, F,Z,T,Z,F,F};
      vecs[8]  = '{F,F,F,T,F,Z,            2'b00,F,F,A1,W1, F,Z,F,Z,F,F};
      // Continuous contention: m1 served last, so order is m0, m1, m0.
      vecs[9]  = '{T,F,F,T,F,Z,            2'b01,T,F,A0,W0, F,Z,F,Z,F,F};
      vecs[10] = '{T,F,F,T,T,32'h11111111, 2'b01,F,F,A0,W0, T,32'h11111111,F,Z,F,F};
      vecs[11] = '{T,F,F,T,F,Z,            2'b00,F,F,A0,W0, F,Z,F,Z,F,F};
      vecs[12] = '{T,F,F,T,F,Z,            2'b10,F,T,A1,W1, F,Z,F,Z,F,F};
      vecs[13] = '{T,F,F,T,T,32'h33333333, 2'b10,F,F,A1,W1, F,Z,T,Z,F,F};
      vecs[14] = '{T,F,F,T,F,Z,            2'b00,F,F,A1,W1, F,Z,F,Z,F,F};
      vecs[15] = '{T,F,F,T,F,Z,            2'b01,T,F,A0,W0, F,Z,F,Z,F,F};
      vecs[16] = '{T,F,F,T,T,32'h22222222, 2'b01,F,F,A0,W0, T,32'h22222222,F,Z,F,F};
      vecs[17] = '{F,F,F,F,F,Z,            2'b00,F,F,A0,W0, F,Z,F,Z,F,F};
      // read and write both high is a write; write returns rdata 0.
      vecs[18] = '{T,T,F,F,F,Z,            2'b01,F,T,A0,W0, F,Z,F,Z,F,F};
      vecs[19] = '{T,T,F,F,T,32'h44444444, 2'b01,F,F,A0,W0, T,Z,F,Z,F,F};
      vecs[20] = '{F,F,F,F,F,Z,            2'b00,F,F,A0,W0, F,Z,F,Z,F,F};

      zero = '{F,F,F,F,F,Z, 2'b00,F,F,Z,Z, F,Z,F,Z,F,F};

      rst_n = 1'b0;
      m0_addr = A0; m0_wdata = W0; m1_addr = A1; m1_wdata = W1;
      apply(zero);
      repeat (3) tick();
      check_out("reset", zero);
      chk("reset err_count", 32'(err_count), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 21; i++) begin
         apply(vecs[i]);
         tick();
         check_out($sformatf("v%0d", i), vecs[i]);
      end

      // Watchdog: m0 read never answered, abort on the 4th BUSY edge.
      m0_read = 1'b1; mem_ready = 1'b0;
      tick();
      chk("to grant", 32'(grant), 32'd1);
      chk("to mem_read", 32'(mem_read), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("to busy%0d mem_read", i), 32'(mem_read), 32'd1);
         chk($sformatf("to busy%0d m0_err", i), 32'(m0_err), 32'd0);
      end
      tick();
      chk("to m0_err", 32'(m0_err), 32'd1);
      chk("to m0_ready", 32'(m0_ready), 32'd0);
      chk("to m0_rdata", m0_rdata, 32'd0);
      chk("to err_count", 32'(err_count), 32'd1);
      chk("to mem_read cleared", 32'(mem_read), 32'd0);
      chk("to grant held", 32'(grant), 32'd1);
      tick();
      chk("to m0_err drop", 32'(m0_err), 32'd0);
      chk("to grant clear", 32'(grant), 32'd0);
      // Next request served normally.
      mem_ready = 1'b1; mem_rdata = 32'h5A5A5A5A;
      tick();
      chk("rec mem_read", 32'(mem_read), 32'd1);
      chk("rec m0_ready early", 32'(m0_ready), 32'd0);
      tick();
      chk("rec m0_ready", 32'(m0_ready), 32'd1);
      chk("rec m0_rdata", m0_rdata, 32'h5A5A5A5A);
      chk("rec err_count", 32'(err_count), 32'd1);
      tick();
      m0_read = 1'b0; mem_ready = 1'b0;

      // Async reset mid-BUSY of an m1 write; m0 was served last.
      m1_write = 1'b1;
      tick();
      chk("rst grant before", 32'(grant), 32'd2);
      tick();
      chk("rst mem_write before", 32'(mem_write), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst mem_write", 32'(mem_write), 32'd0);
      chk("rst grant", 32'(grant), 32'd0);
      chk("rst err_count", 32'(err_count), 32'd0);
      chk("rst mem_addr", mem_addr, 32'd0);
      m0_read = 1'b1; mem_ready = 1'b1;
      tick();
      chk("rst hold m1_ready", 32'(m1_ready), 32'd0);
      chk("rst hold m1_err", 32'(m1_err), 32'd0);
      chk("rst hold m0_ready", 32'(m0_ready), 32'd0);
      chk("rst hold grant", 32'(grant), 32'd0);
      rst_n = 1'b1; mem_ready = 1'b0;
      tick();
      chk("post rst grant", 32'(grant), 32'd1);
      chk("post rst mem_read", 32'(mem_read), 32'd1);
      mem_ready = 1'b1; mem_rdata = 32'h77777777;
      tick();
      chk("post rst m0_ready", 32'(m0_ready), 32'd1);
      chk("post rst m0_rdata", m0_rdata, 32'h77777777);
      chk("post rst m1_ready", 32'(m1_ready), 32'd0);
      m0_read = 1'b0; m1_write = 1'b0; mem_ready = 1'b0;
      tick();

      // mem_ready on the watchdog edge: completion wins.
      m1_read = 1'b1;
      tick();
      chk("co grant", 32'(grant), 32'd2);
      chk("co mem_addr", mem_addr, A1);
      repeat (3) tick();
      chk("co mem_read still", 32'(mem_read), 32'd1);
      mem_ready = 1'b1; mem_rdata = 32'h0BADCAFE;
      tick();
      chk("co m1_ready", 32'(m1_ready), 32'd1);
      chk("co m1_rdata", m1_rdata, 32'h0BADCAFE);
      chk("co m1_err", 32'(m1_err), 32'd0);
      chk("co err_count", 32'(err_count), 32'd0);
      chk("co m0_rdata", m0_rdata, 32'd0);
      mem_ready = 1'b0;
      tick();
      m1_read = 1'b0;
      chk("co m1_ready drop", 32'(m1_ready), 32'd0);
      chk("co grant clear", 32'(grant), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
